// File: rtl/timebase_if.sv
// Peripheral-bus request/response bundle for the timebase generator.
interface timebase_if;
    logic        timebase_valid;
    logic [7:0]  timebase_addr;
    logic [31:0] timebase_wdata;
    logic [3:0]  timebase_wstrb;
    logic [31:0] timebase_rdata;
    logic        timebase_ready;

    modport master (
        output timebase_valid, timebase_addr, timebase_wdata, timebase_wstrb,
        input  timebase_rdata, timebase_ready
    );

    modport slave (
        input  timebase_valid, timebase_addr, timebase_wdata, timebase_wstrb,
        output timebase_rdata, timebase_ready
    );
endinterface

// File: rtl/timebase_gen.sv
// Multi-channel programmable tick / square-wave clock-enable generator.
// Pending/mask interrupt logic is built only when TIMEBASE_IRQ_EN is defined.
module timebase_gen #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DIV_WIDTH = 16,
    parameter logic [CHANNELS*DIV_WIDTH-1:0] DIV_RESET = {16'd216, 16'd380},
    parameter logic [CHANNELS-1:0] EN_RESET = {CHANNELS{1'b1}}
) (
    input  logic                clock,
    input  logic                reset,
    timebase_if.slave           bus,
    output logic [CHANNELS-1:0] tick_o,
    output logic [CHANNELS-1:0] square_o,
    output logic                irq_o
);

    localparam int unsigned CW = DIV_WIDTH;

    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CW-1:0]       div_q [CHANNELS];
    logic [CW-1:0]       div_d [CHANNELS];
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] sq_q, sq_d;
    logic [CHANNELS-1:0] div_wr;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                req, wr;
    logic [5:0]          idx;
    logic [31:0]         bm;
    logic                unused_bits;
`ifdef TIMEBASE_IRQ_EN
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic                irq_q, irq_d;
`endif

    // A request is taken once; the ready cycle itself never re-triggers it.
    assign req = bus.timebase_valid && !ready_q;
    assign wr  = req && (bus.timebase_wstrb != 4'b0);
    assign idx = bus.timebase_addr[7:2];
    assign bm  = {{8{bus.timebase_wstrb[3]}}, {8{bus.timebase_wstrb[2]}},
                  {8{bus.timebase_wstrb[1]}}, {8{bus.timebase_wstrb[0]}}};
    assign unused_bits = ^{bus.timebase_addr[1:0], bus.timebase_wdata};

    always_comb begin
        rdata_d = '0;
        if (req && !wr) begin
            if (idx == 6'd0) begin
                rdata_d[CHANNELS-1:0] = en_q;
`ifdef TIMEBASE_IRQ_EN
                rdata_d[16 +: CHANNELS] = mask_q;
`endif
            end
`ifdef TIMEBASE_IRQ_EN
            if (idx == 6'd1)
                rdata_d[CHANNELS-1:0] = pend_q;
`endif
            for (int i = 0; i < CHANNELS; i++)
                if (idx == 6'(i + 2))
                    rdata_d[CW-1:0] = div_q[i];
        end
    end

    always_comb begin
        en_d   = en_q;
        div_wr = '0;
        for (int i = 0; i < CHANNELS; i++)
            div_d[i] = div_q[i];
        if (wr && idx == 6'd0)
            for (int i = 0; i < CHANNELS; i++)
                if (bm[i])
                    en_d[i] = bus.timebase_wdata[i];
        for (int i = 0; i < CHANNELS; i++)
            if (wr && idx == 6'(i + 2)) begin
                div_wr[i] = 1'b1;
                for (int b = 0; b < CW; b++)
                    if (bm[b])
                        div_d[i][b] = bus.timebase_wdata[b];
            end
    end

    // The next enable gates the counter so a disabling write suppresses the tick.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            tick_d[i] = 1'b0;
            sq_d[i]   = sq_q[i];
            if (!en_d[i]) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (en_q[i]) begin
                if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
                if (div_wr[i])
                    cnt_d[i] = '0;
            end
        end
    end

    assign ready_d = req;

`ifdef TIMEBASE_IRQ_EN
    always_comb begin
        mask_d = mask_q;
        pend_d = pend_q;
        if (wr && idx == 6'd0)
            for (int i = 0; i < CHANNELS; i++)
                if (bm[16 + i])
                    mask_d[i] = bus.timebase_wdata[16 + i];
        if (wr && idx == 6'd1)
            pend_d = pend_q & ~(bus.timebase_wdata[CHANNELS-1:0] &
                                bm[CHANNELS-1:0]);
        // A tick in the same cycle as a clear wins.
        pend_d = pend_d | tick_d;
        irq_d  = |(pend_d & mask_d);
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DIV_RESET[i*CW +: CW];
            end
            en_q    <= EN_RESET;
            tick_q  <= '0;
            sq_q    <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
`ifdef TIMEBASE_IRQ_EN
            pend_q  <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            en_q    <= en_d;
            tick_q  <= tick_d;
            sq_q    <= sq_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
`ifdef TIMEBASE_IRQ_EN
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            irq_q   <= irq_d;
`endif
        end
    end

    assign bus.timebase_ready = ready_q;
    assign bus.timebase_rdata = rdata_q;
    assign tick_o   = tick_q;
    assign square_o = sq_q;
`ifdef TIMEBASE_IRQ_EN
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_timebase_gen.sv
// Scoreboard bench for timebase_gen: bus responses are queued at issue
// and checked by a monitor; tick/square activity is logged per cycle.
module tb_timebase_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] tick_o;
    logic [1:0] square_o;
    logic       irq_o;

    timebase_if bus ();

    timebase_gen dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .tick_o   (tick_o),
        .square_o (square_o),
        .irq_o    (irq_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t       sb [$];
    int         log0 [$];
    int         log1 [$];
    int         sqlog0 [$];
    int         sqlog1 [$];
    logic [1:0] sq_prev = 2'b00;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clock or negedge reset)
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: responses are expected exactly one cycle after acceptance.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0 && cyc == sb[0].cyc) begin
            e = sb.pop_front();
            chk("ready", bus.timebase_ready, 1);
            if (bus.timebase_ready)
                chk("rdata", bus.timebase_rdata, e.data);
        end else if (bus.timebase_ready) begin
            chk("unexpected ready", bus.timebase_ready, 0);
        end
        if (reset) begin
            if (tick_o[0]) log0.push_back(cyc);
            if (tick_o[1]) log1.push_back(cyc);
            if (square_o[0] != sq_prev[0]) sqlog0.push_back(cyc);
            if (square_o[1] != sq_prev[1]) sqlog1.push_back(cyc);
        end
        sq_prev = square_o;
    end

    task automatic bus_xfer(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] exp,
                            output int acc);
        acc = cyc + 1;
        sb.push_back('{data: exp, cyc: acc});
        bus.timebase_valid = 1'b1;
        bus.timebase_addr  = a;
        bus.timebase_wdata = d;
        bus.timebase_wstrb = s;
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus.timebase_valid = 1'b0;
        bus.timebase_wstrb = 4'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.timebase_valid = 1'b0;
        bus.timebase_addr  = 8'h0;
        bus.timebase_wdata = 32'h0;
        bus.timebase_wstrb = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset tick_o", tick_o, 0);
        chk("reset square_o", square_o, 0);
        chk("reset irq_o", irq_o, 0);
        chk("reset ready", bus.timebase_ready, 0);
        chk("reset rdata", bus.timebase_rdata, 0);
        reset = 1'b1;

        // Reset defaults
        bus_xfer(8'h08, 0, 4'h0, 32'd380, w);
        bus_xfer(8'h0C, 0, 4'h0, 32'd216, w);
        bus_xfer(8'h00, 0, 4'h0, 32'h3, w);
        wait_until(1150);
        chk("ch0 tick #1", log0[0], 381);
        chk("ch0 tick #2", log0[1], 762);
        chk("ch1 tick #1", log1[0], 217);
        chk("sq0 first toggle", sqlog0[0], 381);
        chk("sq0 period", sqlog0[2] - sqlog0[0], 762);

        // Reprogram ch1 mid-count
        bus_xfer(8'h0C, 32'd3, 4'hF, 0, w);
        log1.delete();
        wait_until(w + 13);
        chk("div3 tick a", log1[0], w + 4);
        chk("div3 tick b", log1[1], w + 8);
        chk("div3 tick c", log1[2], w + 12);

        bus_xfer(8'h0C, 32'd0, 4'hF, 0, w);
        log1.delete();
        sqlog1.delete();
        wait_until(w + 6);
        chk("div0 tick count", log1.size(), 5);
        chk("div0 first tick", log1[0], w + 1);
        chk("div0 last tick", log1[4], w + 5);
        chk("div0 square toggles", sqlog1.size(), 5);

        // Enable control
        bus_xfer(8'h00, 32'h1, 4'hF, 0, w);
        log1.delete();
        sqlog1.delete();
        wait_until(w + 10);
        chk("disabled no tick", log1.size(), 0);
        chk("disabled square", square_o[1], 0);
        chk("disabled square quiet", sqlog1.size(), 0);
        bus_xfer(8'h0C, 32'd5, 4'hF, 0, w);
        bus_xfer(8'h00, 32'h3, 4'hF, 0, w);
        log1.delete();
        wait_until(w + 8);
        chk("enable first tick", log1[0], w + 6);
        bus_xfer(8'h00, 0, 4'h0, 32'h3, w);

        // Byte strobes, unmapped space, back-to-back traffic
        bus_xfer(8'h08, 32'hAABBCC12, 4'b0001, 0, w);
        bus_xfer(8'h08, 0, 4'h0, 32'h112, w);
        bus_xfer(8'h40, 0, 4'h0, 32'h0, w);
        bus_xfer(8'h40, 32'hFFFFFFFF, 4'hF, 0, w);
        bus_xfer(8'h0C, 0, 4'h0, 32'd5, w);
        bus_xfer(8'h08, 32'hFFFF0007, 4'hF, 0, w);
        log0.delete();
        wait_until(w + 20);
        chk("div7 tick a", log0[0], w + 8);
        chk("div7 tick b", log0[1], w + 16);
        bus_xfer(8'h08, 0, 4'h0, 32'h7, w);
        bus_xfer(8'h00, 32'hFFFF0003, 4'hF, 0, w);
`ifdef TIMEBASE_IRQ_EN
        bus_xfer(8'h00, 0, 4'h0, 32'h00030003, w);
        bus_xfer(8'h00, 32'h00010001, 4'hF, 0, w);
        bus_xfer(8'h08, 32'd100, 4'hF, 0, w);
        wait_until(w + 100);
        bus_xfer(8'h04, 32'h3, 4'hF, 0, w);
        bus_xfer(8'h04, 0, 4'h0, 32'h1, w);
        #1;
        chk("irq after tick", irq_o, 1);
        bus_xfer(8'h04, 32'h3, 4'hF, 0, w);
        bus_xfer(8'h04, 0, 4'h0, 32'h0, w);
        #1;
        chk("irq after clear", irq_o, 0);
`else
        bus_xfer(8'h00, 0, 4'h0, 32'h3, w);
        bus_xfer(8'h04, 0, 4'h0, 32'h0, w);
        #1;
        chk("irq tied low", irq_o, 0);
`endif

        // Asynchronous reset mid-request and mid-count
        @(posedge clock); #1;
        bus.timebase_valid = 1'b1;
        bus.timebase_addr  = 8'h0C;
        bus.timebase_wstrb = 4'h0;
        #2;
        reset = 1'b0;
        #1;
        chk("async tick_o", tick_o, 0);
        chk("async square_o", square_o, 0);
        chk("async irq_o", irq_o, 0);
        chk("async ready", bus.timebase_ready, 0);
        @(posedge clock); #1;
        bus.timebase_valid = 1'b0;
        chk("dropped request", bus.timebase_ready, 0);
        @(posedge clock); #1;
        log0.delete();
        log1.delete();
        reset = 1'b1;
        bus_xfer(8'h0C, 0, 4'h0, 32'd216, w);
        wait_until(400);
        chk("post-reset ch0 tick", log0[0], 381);
        chk("post-reset ch1 tick", log1[0], 217);
        chk("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
